// File: rtl/tl_a_fragment_sequencer_if.sv
// A-channel bundle (address/param/mask, no data) between a producer (master)
// and a consumer (slave). replay runs slave->master and asks the producer to
// hold and re-present the current request; frag_rem runs master->slave.
interface tl_a_fragment_sequencer_if #(
    parameter int ADDR_W = 33,
    parameter int SRC_W  = 6,
    parameter int MASK_W = 8,
    parameter int FRAG_W = 3
);
    logic              valid;
    logic              ready;
    logic              replay;
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [2:0]        size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [FRAG_W-1:0] frag_rem;

    modport master (
        output valid, opcode, param, size, source, address, mask, frag_rem,
        input  ready, replay
    );

    modport slave (
        input  valid, opcode, param, size, source, address, mask, frag_rem,
        output ready, replay
    );
endinterface

// File: rtl/tl_a_fragment_sequencer.sv
// Splits a held A request into naturally aligned fragments of at most
// 2^MAX_LG_SIZE bytes, asking the upstream repeater to replay the request
// until the last fragment has been accepted downstream.
//
// idx_q            | meaning
// -----------------+--------------------------------------------------
// 0                | idle, or first fragment of a request on offer
// 1 .. total       | fragment idx_q of the held request on offer
module tl_a_fragment_sequencer #(
    parameter int MAX_LG_SIZE = 3,
    parameter int MAX_IN_LG   = 6,
    parameter int ADDR_W      = 33,
    parameter int SRC_W       = 6
) (
    input logic clock,
    input logic reset,
    tl_a_fragment_sequencer_if.slave  in_a,
    tl_a_fragment_sequencer_if.master out_a
);
    localparam int MASK_W = 1 << MAX_LG_SIZE;
    localparam int FRAG_W = MAX_IN_LG - MAX_LG_SIZE;

    logic [FRAG_W-1:0] idx_q;
    logic [FRAG_W-1:0] idx_d;
    logic [FRAG_W-1:0] total;
    logic [FRAG_W-1:0] field;
    logic [2:0]        eff_size;
    logic              big;
    logic              last;
    logic              fire;

    // Fragment index register; reset aborts any burst in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) idx_q <= '0;
        else       idx_q <= idx_d;
    end

    // Fragment count for the request on offer, last-fragment detect, next index.
    // Oversized requests are clamped so total saturates instead of wrapping.
    always_comb begin
        eff_size = (in_a.size > 3'(MAX_IN_LG)) ? 3'(MAX_IN_LG) : in_a.size;
        big      = eff_size > 3'(MAX_LG_SIZE);
        total    = '0;
        if (big) total = FRAG_W'((32'd1 << (eff_size - 3'(MAX_LG_SIZE))) - 32'd1);
        last     = (idx_q == total);
        fire     = in_a.valid & out_a.ready;
        idx_d    = idx_q;
        if (fire) idx_d = last ? '0 : idx_q + FRAG_W'(1);
    end

    // Zero-latency pass-through with the fragment offset merged into the address.
    // Only the bits covered by total are replaced, so higher aligned base bits survive.
    always_comb begin
        out_a.valid    = in_a.valid;
        in_a.ready     = out_a.ready;
        in_a.replay    = in_a.valid & ~last;
        out_a.opcode   = in_a.opcode;
        out_a.param    = in_a.param;
        out_a.source   = in_a.source;
        out_a.size     = (in_a.size > 3'(MAX_LG_SIZE)) ? 3'(MAX_LG_SIZE) : in_a.size;
        out_a.mask     = big ? '1 : in_a.mask;
        out_a.frag_rem = total - idx_q;
        field          = (in_a.address[MAX_LG_SIZE +: FRAG_W] & ~total) | idx_q;
        out_a.address  = in_a.address;
        if (big) out_a.address[MAX_LG_SIZE +: FRAG_W] = field;
    end

`ifndef SYNTHESIS
    logic [2:0]        sh_opcode;
    logic [2:0]        sh_size;
    logic [SRC_W-1:0]  sh_source;
    logic [ADDR_W-1:0] sh_address;

    // Capture the request at its first fragment so later replays can be compared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_opcode  <= '0;
            sh_size    <= '0;
            sh_source  <= '0;
            sh_address <= '0;
        end else if (fire && idx_q == '0) begin
            sh_opcode  <= in_a.opcode;
            sh_size    <= in_a.size;
            sh_source  <= in_a.source;
            sh_address <= in_a.address;
        end
    end

    // Mid-burst the repeater must keep presenting the same request; sizes are bounded.
    always @(posedge clock) begin
        if (!reset) begin
            if (in_a.valid) begin
                a_size_legal: assert (in_a.size <= 3'(MAX_IN_LG));
            end
            if (idx_q != '0) begin
                a_req_held: assert (in_a.valid && in_a.opcode == sh_opcode &&
                                    in_a.size == sh_size && in_a.source == sh_source &&
                                    in_a.address == sh_address);
            end
        end
    end
`endif
endmodule

// File: tb/tb_tl_a_fragment_sequencer.sv
// Directed and randomized checks of the A-channel fragment sequencer against a
// request-level model: a request of 2^size bytes becomes max(1, 2^(size-3))
// fragments at base + 8*k.
module tb_tl_a_fragment_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    tl_a_fragment_sequencer_if #(.ADDR_W(33), .SRC_W(6), .MASK_W(8), .FRAG_W(3)) in_if ();
    tl_a_fragment_sequencer_if #(.ADDR_W(33), .SRC_W(6), .MASK_W(8), .FRAG_W(3)) out_if ();

    tl_a_fragment_sequencer #(
        .MAX_LG_SIZE(3), .MAX_IN_LG(6), .ADDR_W(33), .SRC_W(6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .in_a  (in_if),
        .out_a (out_if)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    int          r_size;
    logic [32:0] r_addr;
    logic [7:0]  r_mask;
    logic [2:0]  r_op;
    logic [2:0]  r_param;
    logic [5:0]  r_src;
    int          k;

    function automatic int nfrags(input int s);
        return (s > 3) ? (1 << (s - 3)) : 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int s, input logic [32:0] a, input logic [7:0] m);
        r_size  = s;
        r_addr  = a;
        r_mask  = m;
        r_op    = 3'($urandom_range(0, 7));
        r_param = 3'($urandom_range(0, 7));
        r_src   = 6'($urandom_range(0, 63));
        k       = 0;
        in_if.size    = 3'(s);
        in_if.address = a;
        in_if.mask    = m;
        in_if.opcode  = r_op;
        in_if.param   = r_param;
        in_if.source  = r_src;
    endtask

    // Compare all outputs with the model for the current fragment.
    task automatic check_outputs(input bit v, input bit rdy);
        int n;
        n = nfrags(r_size);
        chk("out_valid", 64'(out_if.valid), 64'(v));
        chk("in_ready", 64'(in_if.ready), 64'(rdy));
        if (v) begin
            chk("in_repeat", 64'(in_if.replay), 64'(k != n - 1));
            chk("out_address", 64'(out_if.address), 64'(r_addr) + 64'(k * 8));
            chk("out_size", 64'(out_if.size), 64'((r_size > 3) ? 3 : r_size));
            chk("out_mask", 64'(out_if.mask), 64'((r_size > 3) ? 8'hFF : r_mask));
            chk("out_frag_rem", 64'(out_if.frag_rem), 64'(n - 1 - k));
            chk("passthru", 64'({out_if.opcode, out_if.param, out_if.source}),
                64'({r_op, r_param, r_src}));
        end else begin
            chk("in_repeat_idle", 64'(in_if.replay), 64'(0));
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input bit v, input bit rdy);
        in_if.valid  = v;
        out_if.ready = rdy;
        #1;
        check_outputs(v, rdy);
        @(posedge clock);
        if (v && rdy) k = (k + 1 == nfrags(r_size)) ? 0 : k + 1;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_if.valid     = 1'b0;
        in_if.frag_rem  = '0;
        out_if.ready    = 1'b0;
        out_if.replay   = 1'b0;
        set_req(0, 33'h0, 8'h0);
        @(negedge clock);
        @(negedge clock);

        // reset state: idle outputs, then index 0 visible with a request held
        #1;
        chk("rst_out_valid", 64'(out_if.valid), 64'(0));
        chk("rst_in_repeat", 64'(in_if.replay), 64'(0));
        set_req(6, 33'h1_0000_0040, 8'h00);
        in_if.valid = 1'b1;
        #1;
        chk("rst_frag_rem", 64'(out_if.frag_rem), 64'(7));
        chk("rst_address", 64'(out_if.address), 64'(33'h1_0000_0040));
        in_if.valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // 1: size 6 -> eight 8-byte fragments
        set_req(6, 33'h1_0000_0040, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // 2: size 2 single fragment
        set_req(2, 33'h0_0000_0104, 8'h0F);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // 3: size 3 passes mask
        set_req(3, 33'h0_0000_0208, 8'h5A);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // 4: size 4 with ready 1,0,0,1
        set_req(4, 33'h0_1234_5670, 8'h00);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // 5: back-to-back size 4 requests, no bubble
        set_req(4, 33'h0_0000_0200, 8'h00);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        set_req(4, 33'h1_FFFF_FF30, 8'h00);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // 6: reset between fragment 2 and 3 of a size 5 request
        set_req(5, 33'h0_ABCD_0020, 8'h00);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        reset = 1'b1;
        k = 0;
        #1;
        chk("rst_mid_frag_rem", 64'(out_if.frag_rem), 64'(3));
        chk("rst_mid_address", 64'(out_if.address), 64'(33'h0_ABCD_0020));
        in_if.valid = 1'b0;
        #1;
        chk("rst_mid_in_repeat", 64'(in_if.replay), 64'(0));
        chk("rst_mid_out_valid", 64'(out_if.valid), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        set_req(5, 33'h0_ABCD_0020, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // randomized requests with random downstream stalls and idle gaps
        for (int r = 0; r < 40; r++) begin
            int          s;
            int          n;
            int          fired;
            logic [32:0] a;
            s = $urandom_range(0, 6);
            a = {1'($urandom_range(0, 1)), 32'($urandom)};
            a = a & ~((33'd1 << s) - 33'd1);
            set_req(s, a, 8'($urandom_range(0, 255)));
            n = nfrags(s);
            fired = 0;
            for (int c = 0; c < 400 && fired < n; c++) begin
                bit rdy;
                rdy = ($urandom_range(0, 3) != 0);
                step(1'b1, rdy);
                if (rdy) fired++;
            end
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
